mem_arbiter: RTL

Two-port arbiter sharing the single `memory` instance between two requesters in `uc_top`: port 0 is the controller's MAR/MBR path, port 1 is the port-1 load path. It serialises accesses using the memory's `enable`/`rw`/`addr`/`mfc` handshake and grants round-robin on contention. It bounds every access with an `mfc` timeout and returns read data plus per-port done/error pulses.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_rr.sv | 22 ++
 rtl/mem_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic OWNER_P0 = 1'b0;
    localparam logic OWNER_P1 = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational 2-way round-robin picker: on a tie the port that did not go last wins.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic valid,
    output logic id
);

    always_comb begin
        valid = req0 | req1;
        id    = OWNER_P0;
        if (req0 && req1) begin
            id = (last_owner == OWNER_P0) ? OWNER_P1 : OWNER_P0;
        end else if (req1) begin
            id = OWNER_P1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises two requesters onto one memory with an mfc handshake, round-robin
// arbitration on contention and a per-access mfc timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_rw,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_rw,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_done,
    output logic              r0_err,
    output logic              r1_done,
    output logic              r1_err,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_mfc,
    output logic              busy,
    output logic              owner
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    state_t             state, state_d;
    logic               last_owner;
    logic               gnt_valid, gnt_id;
    logic               cmd_rw;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [DATA_W-1:0]  cmd_wdata;
    logic [CNT_W-1:0]   cnt;
    logic               timeout_hit;

    mem_arb_rr u_rr (
        .req0       (r0_req),
        .req1       (r1_req),
        .last_owner (last_owner),
        .valid      (gnt_valid),
        .id         (gnt_id)
    );

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    // Next-state logic; mfc takes priority over a simultaneous timeout.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (gnt_valid) state_d = ACCESS;
            ACCESS: begin
                if (mem_mfc)          state_d = DONE;
                else if (timeout_hit) state_d = ERR;
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // Command capture at grant, timeout count, read-data capture and fairness history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_rw     <= RW_WRITE;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cnt        <= '0;
            owner      <= OWNER_P0;
            last_owner <= OWNER_P1;
            rdata      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        owner     <= gnt_id;
                        cmd_rw    <= (gnt_id == OWNER_P1) ? r1_rw    : r0_rw;
                        cmd_addr  <= (gnt_id == OWNER_P1) ? r1_addr  : r0_addr;
                        cmd_wdata <= (gnt_id == OWNER_P1) ? r1_wdata : r0_wdata;
                        cnt       <= '0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mem_mfc && (cmd_rw == RW_READ)) rdata <= mem_data_out;
                end
                DONE, ERR: last_owner <= owner;
                default: ;
            endcase
        end
    end

    // Outputs decode purely from registered state and command.
    assign busy        = (state != IDLE);
    assign mem_enable  = (state == ACCESS);
    assign mem_rw      = mem_enable ? cmd_rw    : RW_WRITE;
    assign mem_addr    = mem_enable ? cmd_addr  : '0;
    assign mem_data_in = mem_enable ? cmd_wdata : '0;
    assign r0_done     = (state == DONE) && (owner == OWNER_P0);
    assign r1_done     = (state == DONE) && (owner == OWNER_P1);
    assign r0_err      = (state == ERR)  && (owner == OWNER_P0);
    assign r1_err      = (state == ERR)  && (owner == OWNER_P1);

endmodule
